// File: rtl/adder_pkg.sv
// Shared definitions for the adder block.
//   MAX_WIDTH / MAX_PIPE : legal upper bounds for the WIDTH / PIPE parameters.
//   ovf_flag()           : two's-complement overflow from operand and sum MSBs.
// The result struct depends on the instance WIDTH, so each adder declares it
// locally using these bounds.
package adder_pkg;

  localparam int MAX_WIDTH = 64;
  localparam int MAX_PIPE  = 4;

  // Overflow occurs when both operands have the same sign and the sum's sign
  // differs from theirs.
  function automatic logic ovf_flag(input logic a_msb,
                                    input logic b_msb,
                                    input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_if.sv
// Operand/result bundle for the adder.
//   master : drives a, b, cin, in_valid; observes c, sum_q, cout_q, ovf_q, out_valid
//   slave  : the adder itself (mirror of master)
interface adder_if #(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             in_valid;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             out_valid;

  modport master (
    output a, b, cin, in_valid,
    input  c, sum_q, cout_q, ovf_q, out_valid
  );

  modport slave (
    input  a, b, cin, in_valid,
    output c, sum_q, cout_q, ovf_q, out_valid
  );

endinterface

// File: rtl/adder_stage.sv
// One valid-qualified pipeline register.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : qualifies d; data loads only when high
//   d          : stage input data (DW bits)
//   out_valid  : in_valid delayed by one cycle
//   q          : registered data, held while in_valid is low
module adder_stage #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] d,
  output logic          out_valid,
  output logic [DW-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its neighbour's pre-edge value; blocking here would collapse the
  // pipeline into fewer stages.
  // NOTE: the data register is reset as well, so in-flight results are
  // dropped on reset and sum_q reads 0 immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      q         <= '0;
    end else begin
      out_valid <= in_valid;
      // Gating the load keeps X on idle inputs out of the held value.
      if (in_valid) q <= d;
    end
  end

endmodule

// File: rtl/adder.sv
// Parameterised binary adder.
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus.a, bus.b    : operands (unsigned; signed view used only for ovf)
//   bus.cin         : carry-in, registered path only
//   bus.in_valid    : qualifies a/b/cin for the registered path
//   bus.c           : combinational (a + b) mod 2^WIDTH
//   bus.sum_q       : registered a + b + cin, wrapped or saturated
//   bus.cout_q      : registered unsigned carry-out
//   bus.ovf_q       : registered two's-complement overflow
//   bus.out_valid   : high when the registered outputs hold a result,
//                     PIPE cycles after the accepted in_valid
module adder
  import adder_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int PIPE     = 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic  clk,
  input  logic  rst_n,
  adder_if.slave bus
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("adder: WIDTH out of range");
  end
  if (PIPE < 1 || PIPE > MAX_PIPE) begin : g_bad_pipe
    $error("adder: PIPE out of range");
  end

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } result_t;

  localparam int RES_W = $bits(result_t);

  // Zero-latency path: no carry-in, independent of clock and valid.
  assign bus.c = bus.a + bus.b;

  logic [WIDTH:0] raw;
  result_t        res;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    res  = '0;
    raw  = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
    res.cout = raw[WIDTH];
    res.ovf  = ovf_flag(bus.a[WIDTH-1], bus.b[WIDTH-1], raw[WIDTH-1]);
    // Clamp only on unsigned carry; ovf is reported independently.
    if (SATURATE && raw[WIDTH]) res.sum = '1;
    else                        res.sum = raw[WIDTH-1:0];
  end

  // Valid and data travel together through PIPE stages.
  logic [PIPE:0]  vld;
  result_t        dat [PIPE+1];

  assign vld[0] = bus.in_valid;
  assign dat[0] = res;

  for (genvar i = 0; i < PIPE; i++) begin : g_stage
    logic [RES_W-1:0] q;

    adder_stage #(.DW(RES_W)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (vld[i]),
      .d        (dat[i]),
      .out_valid(vld[i+1]),
      .q        (q)
    );

    assign dat[i+1] = result_t'(q);
  end

  assign bus.sum_q     = dat[PIPE].sum;
  assign bus.cout_q    = dat[PIPE].cout;
  assign bus.ovf_q     = dat[PIPE].ovf;
  assign bus.out_valid = vld[PIPE];

endmodule

// File: tb/tb_adder.sv
// Directed self-checking bench for adder: three instances cover the 1-bit
// half adder, an 8-bit three-stage wrap pipeline and an 8-bit saturating stage.
module tb_adder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  adder_if #(.WIDTH(1)) if1 ();
  adder_if #(.WIDTH(8)) if8 ();
  adder_if #(.WIDTH(8)) ifs ();

  adder #(.WIDTH(1), .PIPE(1), .SATURATE(1'b0)) u_w1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));
  adder #(.WIDTH(8), .PIPE(3), .SATURATE(1'b0)) u_w8 (
    .clk(clk), .rst_n(rst_n), .bus(if8));
  adder #(.WIDTH(8), .PIPE(1), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(ifs));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks all registered outputs of the 8-bit pipelined instance.
  task automatic chk8(input string tag, input logic v, input logic [7:0] s,
                      input logic co, input logic ov);
    check({tag, " valid"}, 64'(if8.out_valid), 64'(v));
    check({tag, " sum"},   64'(if8.sum_q),     64'(s));
    check({tag, " cout"},  64'(if8.cout_q),    64'(co));
    check({tag, " ovf"},   64'(if8.ovf_q),     64'(ov));
  endtask

  // Combinational 1-bit truth table: {a,b} -> c
  logic [1:0] tt_in  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic       tt_out [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  // Saturating vectors: a, b, cin, expected sum, cout, ovf
  typedef struct {
    logic [7:0] a; logic [7:0] b; logic cin;
    logic [7:0] s; logic co; logic ov;
  } sat_vec_t;
  sat_vec_t sat_tab [4] = '{
    '{8'hF0, 8'h20, 1'b1, 8'hFF, 1'b1, 1'b0},  // carry -> clamp
    '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0},  // max operands, raw = 0x1FF
    '{8'h80, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1},  // clamp and signed overflow
    '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1}   // overflow without carry
  };

  initial begin
    rst_n = 1'b0;
    if1.a = '0; if1.b = '0; if1.cin = 1'b0; if1.in_valid = 1'b0;
    if8.a = '0; if8.b = '0; if8.cin = 1'b0; if8.in_valid = 1'b0;
    ifs.a = '0; ifs.b = '0; ifs.cin = 1'b0; ifs.in_valid = 1'b0;

    // Reset state
    #2;
    check("rst w1 valid", 64'(if1.out_valid), 64'd0);
    check("rst w8 valid", 64'(if8.out_valid), 64'd0);
    check("rst w8 sum",   64'(if8.sum_q),     64'd0);
    check("rst sat sum",  64'(ifs.sum_q),     64'd0);
    #10 rst_n = 1'b1;
    @(negedge clk);

    // Combinational half-adder sum, 10 ns per vector
    for (int i = 0; i < 4; i++) begin
      {if1.a, if1.b} = tt_in[i];
      #1;
      check($sformatf("c w1 %b", tt_in[i]), 64'(if1.c), 64'(tt_out[i]));
      #9;
    end
    if8.a = 8'hC8; if8.b = 8'h64;
    #1 check("c w8 wrap", 64'(if8.c), 64'h2C);

    // 1-bit registered path: 1 + 1
    if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b0; if1.in_valid = 1'b1;
    tick();
    if1.in_valid = 1'b0;
    check("w1 sum",   64'(if1.sum_q),     64'd0);
    check("w1 cout",  64'(if1.cout_q),    64'd1);
    check("w1 ovf",   64'(if1.ovf_q),     64'd1);
    check("w1 valid", 64'(if1.out_valid), 64'd1);
    tick();
    check("w1 valid drop", 64'(if1.out_valid), 64'd0);

    // 8-bit, 3-stage back-to-back stream
    if8.cin = 1'b0; if8.in_valid = 1'b1;
    if8.a = 8'h7F; if8.b = 8'h01; tick();
    if8.a = 8'hFF; if8.b = 8'h01; tick();
    check("w8 lat valid", 64'(if8.out_valid), 64'd0);
    if8.a = 8'h10; if8.b = 8'h20; tick();
    if8.in_valid = 1'b0;
    chk8("w8 r0", 1'b1, 8'h80, 1'b0, 1'b1);
    tick();
    chk8("w8 r1", 1'b1, 8'h00, 1'b1, 1'b0);
    tick();
    chk8("w8 r2", 1'b1, 8'h30, 1'b0, 1'b0);
    tick();
    chk8("w8 idle", 1'b0, 8'h30, 1'b0, 1'b0);

    // Saturating instance, one-cycle latency, back-to-back
    ifs.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ifs.a = sat_tab[i].a; ifs.b = sat_tab[i].b; ifs.cin = sat_tab[i].cin;
      tick();
      check($sformatf("sat%0d sum", i),  64'(ifs.sum_q),  64'(sat_tab[i].s));
      check($sformatf("sat%0d cout", i), 64'(ifs.cout_q), 64'(sat_tab[i].co));
      check($sformatf("sat%0d ovf", i),  64'(ifs.ovf_q),  64'(sat_tab[i].ov));
    end
    ifs.in_valid = 1'b0;

    // Wrap-mode max operands with carry-in
    if8.a = 8'hFF; if8.b = 8'hFF; if8.cin = 1'b1; if8.in_valid = 1'b1;
    tick();
    if8.in_valid = 1'b0; if8.cin = 1'b0;
    tick(); tick();
    chk8("w8 max", 1'b1, 8'hFF, 1'b1, 1'b0);
    tick();

    // Asynchronous reset with two results in flight
    if8.in_valid = 1'b1;
    if8.a = 8'h01; if8.b = 8'h02; tick();
    if8.a = 8'h04; if8.b = 8'h05; tick();
    if8.in_valid = 1'b0;
    check("pre-rst held sum", 64'(if8.sum_q), 64'hFF);
    #3 rst_n = 1'b0;
    #1;
    chk8("async rst", 1'b0, 8'h00, 1'b0, 1'b0);
    check("async rst sat sum", 64'(ifs.sum_q), 64'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk8($sformatf("post-rst c%0d", i), 1'b0, 8'h00, 1'b0, 1'b0);
    end

    // in_valid 1,0,1 with X operands in the gap
    if8.in_valid = 1'b1; if8.a = 8'h11; if8.b = 8'h22; tick();
    if8.in_valid = 1'b0; if8.a = 8'hxx; if8.b = 8'hxx; if8.cin = 1'bx; tick();
    if8.in_valid = 1'b1; if8.a = 8'h40; if8.b = 8'h01; if8.cin = 1'b0; tick();
    if8.in_valid = 1'b0; if8.a = 8'hxx; if8.b = 8'hxx; if8.cin = 1'bx;
    chk8("gap r0", 1'b1, 8'h33, 1'b0, 1'b0);
    tick();
    chk8("gap hold", 1'b0, 8'h33, 1'b0, 1'b0);
    tick();
    chk8("gap r1", 1'b1, 8'h41, 1'b0, 1'b0);
    tick();
    chk8("gap end", 1'b0, 8'h41, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
